// File: rtl/hcsr04_echo_emu.sv
// HC-SR04 ultrasonic sensor emulator: turns a trigger pulse into a distance-coded echo pulse.
// Optional echo counter port echo_cnt is built when HCSR04_EMU_CNT_EN is defined.
module hcsr04_echo_emu #(
    parameter int CLK_PER_US  = 50,
    parameter int TRIG_MIN_US = 10,
    parameter int BURST_US    = 200,
    parameter int US_PER_CM   = 58,
    parameter int MAX_CM      = 400,
    parameter int TIMEOUT_US  = 38000,
    parameter int HOLDOFF_US  = 10000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trig,
    input  logic [8:0] dist_cm,
    output logic       eco,
    output logic       busy,
    output logic       trig_err
`ifdef HCSR04_EMU_CNT_EN
   ,output logic [15:0] echo_cnt
`endif
);
    localparam int TRIG_CYC = TRIG_MIN_US * CLK_PER_US;
    localparam int WW       = $clog2(TRIG_CYC + 1);
    localparam int PW       = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

    typedef enum logic [2:0] {IDLE, TRIG_HI, BURST, ECHO, HOLDOFF} state_t;

    state_t        state;
    logic          trig_m;
    logic          trig_s;
    logic          armed;
    logic [WW-1:0] wcnt;
    logic [WW-1:0] wcnt_inc;
    logic [PW-1:0] pre;
    logic [15:0]   us_cnt;
    logic [15:0]   dur_us;
    logic [15:0]   w_us;
    logic [8:0]    dist_q;
    logic          tick;
    logic          last;

    // wcnt_inc equals the number of cycles trig_s has been high, saturated at TRIG_CYC.
    always_comb begin
        wcnt_inc = (wcnt == WW'(TRIG_CYC)) ? wcnt : wcnt + WW'(1);
        w_us     = (dist_q >= 9'd1 && dist_q <= 9'(MAX_CM))
                 ? 16'(dist_q) * 16'(US_PER_CM) : 16'(TIMEOUT_US);
        dur_us   = 16'(BURST_US);
        case (state)
            ECHO:    dur_us = w_us;
            HOLDOFF: dur_us = 16'(HOLDOFF_US);
            default: dur_us = 16'(BURST_US);
        endcase
        tick = (pre == PW'(CLK_PER_US - 1));
        last = tick && (us_cnt == dur_us - 16'd1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            trig_m   <= 1'b0;
            trig_s   <= 1'b0;
            armed    <= 1'b0;
            wcnt     <= '0;
            pre      <= '0;
            us_cnt   <= '0;
            dist_q   <= '0;
            eco      <= 1'b0;
            busy     <= 1'b0;
            trig_err <= 1'b0;
`ifdef HCSR04_EMU_CNT_EN
            echo_cnt <= '0;
`endif
        end else begin
            trig_m   <= trig;
            trig_s   <= trig_m;
            trig_err <= 1'b0;
            // Timed states share one prescaler/us counter pair, restarted on each state entry.
            if (state inside {BURST, ECHO, HOLDOFF} && !last) begin
                if (tick) begin
                    pre    <= '0;
                    us_cnt <= us_cnt + 16'd1;
                end else begin
                    pre <= pre + PW'(1);
                end
            end
            case (state)
                IDLE: begin
                    if (!trig_s) begin
                        armed <= 1'b1;
                    end else if (armed) begin
                        state <= TRIG_HI;
                        busy  <= 1'b1;
                        wcnt  <= '0;
                    end
                end
                TRIG_HI: begin
                    if (trig_s) begin
                        wcnt <= wcnt_inc;
                    end else if (wcnt_inc == WW'(TRIG_CYC)) begin
                        dist_q <= dist_cm;
                        state  <= BURST;
                        pre    <= '0;
                        us_cnt <= '0;
                    end else begin
                        trig_err <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                BURST: begin
                    if (last) begin
                        state  <= ECHO;
                        eco    <= 1'b1;
                        pre    <= '0;
                        us_cnt <= '0;
`ifdef HCSR04_EMU_CNT_EN
                        echo_cnt <= echo_cnt + 16'd1;
`endif
                    end
                end
                ECHO: begin
                    if (last) begin
                        state  <= HOLDOFF;
                        eco    <= 1'b0;
                        pre    <= '0;
                        us_cnt <= '0;
                    end
                end
                HOLDOFF: begin
                    // Leaving HOLDOFF disarms, so a trig held high must drop before the next shot.
                    if (last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        armed <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    eco   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hcsr04_echo_emu.sv
// Randomized bench for hcsr04_echo_emu with small timing parameters and a timeline-level model.
module tb_hcsr04_echo_emu;
  localparam int CLK_PER_US  = 4;
  localparam int TRIG_MIN_US = 3;
  localparam int BURST_US    = 5;
  localparam int US_PER_CM   = 3;
  localparam int MAX_CM      = 20;
  localparam int TIMEOUT_US  = 70;
  localparam int HOLDOFF_US  = 10;
  localparam int SAT = TRIG_MIN_US * CLK_PER_US;
  localparam int BC  = BURST_US * CLK_PER_US;
  localparam int HC  = HOLDOFF_US * CLK_PER_US;
  localparam int SYNC_LAT = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       trig;
  logic [8:0] dist_cm;
  logic       eco;
  logic       busy;
  logic       trig_err;
`ifdef HCSR04_EMU_CNT_EN
  logic [15:0] echo_cnt;
`endif

  hcsr04_echo_emu #(
    .CLK_PER_US(CLK_PER_US), .TRIG_MIN_US(TRIG_MIN_US), .BURST_US(BURST_US),
    .US_PER_CM(US_PER_CM), .MAX_CM(MAX_CM), .TIMEOUT_US(TIMEOUT_US), .HOLDOFF_US(HOLDOFF_US)
  ) dut (
    .clk(clk), .rst(rst), .trig(trig), .dist_cm(dist_cm),
    .eco(eco), .busy(busy), .trig_err(trig_err)
`ifdef HCSR04_EMU_CNT_EN
   ,.echo_cnt(echo_cnt)
`endif
  );

  // clock / cycle index (cyc = number of rising edges so far)
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // scoreboard
  logic [31:0] exp_q[$];
  logic [31:0] exp_w_q[$];
  logic [31:0] got_q[$];
  logic [31:0] got_w_q[$];
  int err_seen = 0;
  int err_exp  = 0;
  int echo_exp = 0;

  logic eco_d = 1'b0;
  int   rise_c = 0;
  always @(negedge clk) begin
    if (eco === 1'b1 && eco_d === 1'b0) rise_c = cyc;
    if (eco === 1'b0 && eco_d === 1'b1) begin
      got_q.push_back(rise_c);
      got_w_q.push_back(cyc - rise_c);
    end
    if (trig_err === 1'b1) err_seen++;
    eco_d = eco;
  end

  function automatic int width_cyc(input int d);
    if (d >= 1 && d <= MAX_CM) return d * US_PER_CM * CLK_PER_US;
    return TIMEOUT_US * CLK_PER_US;
  endfunction

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic trig_pulse(input int h, output int k);
    trig = 1'b1;
    k = cyc + 1;
    repeat (h) @(negedge clk);
    trig = 1'b0;
  endtask

  task automatic compare_echoes();
    check("echo_count", got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      check("echo_rise", got_q.pop_front(), exp_q.pop_front());
      check("echo_width", got_w_q.pop_front(), exp_w_q.pop_front());
    end
    got_q.delete(); got_w_q.delete(); exp_q.delete(); exp_w_q.delete();
    check("err_total", err_seen, err_exp);
`ifdef HCSR04_EMU_CNT_EN
    check("echo_cnt", echo_cnt, echo_exp[15:0]);
`endif
  endtask

  // spur: 0 none, 1 extra triggers during ECHO and HOLDOFF, 2 trig held across HOLDOFF end
  task automatic run_trigger(input int h, input int d, input int spur);
    int k, kk, dec, rise, wc, idle;
    dist_cm = 9'(d);
    trig_pulse(h, k);
    dec = k + h + SYNC_LAT;
    if (h < SAT) begin
      err_exp++;
      wait_until(dec);
      check("err_pulse", trig_err, 1);
      check("err_busy", busy, 0);
      step(1);
      check("err_clear", trig_err, 0);
      check("err_eco", eco, 0);
    end else begin
      wc = width_cyc(d);
      rise = dec + BC;
      idle = rise + wc + HC;
      exp_q.push_back(rise);
      exp_w_q.push_back(wc);
      echo_exp++;
      wait_until(dec);
      check("burst_busy", busy, 1);
      dist_cm = 9'($urandom_range(0, 511));
      wait_until(rise - 1);
      check("burst_eco", eco, 0);
      if (spur == 1) begin
        wait_until(rise + $urandom_range(0, wc / 2));
        trig_pulse(SAT + 4, kk);
        dist_cm = 9'($urandom_range(0, 511));
        wait_until(rise + wc + $urandom_range(0, 8));
        trig_pulse(SAT + 4, kk);
      end
      if (spur == 2) begin
        wait_until(idle - 5);
        trig = 1'b1;
      end
      wait_until(idle - 1);
      check("holdoff_busy", busy, 1);
      step(1);
      check("idle_busy", busy, 0);
      check("idle_eco", eco, 0);
      if (spur == 2) begin
        wait_until(idle + 20);
        check("held_busy", busy, 0);
        trig = 1'b0;
        step(20);
        check("released_busy", busy, 0);
      end
    end
    step(3);
    compare_echoes();
  endtask

  function automatic int pick_dist();
    case ($urandom_range(0, 5))
      0: return 0;
      1: return 1;
      2: return MAX_CM;
      3: return MAX_CM + 1;
      4: return 511;
      default: return $urandom_range(0, 511);
    endcase
  endfunction

  initial begin
    int k, rise;
    rst = 1'b1;
    trig = 1'b0;
    dist_cm = '0;
    step(3);
    check("rst_eco", eco, 0);
    check("rst_busy", busy, 0);
    check("rst_err", trig_err, 0);
`ifdef HCSR04_EMU_CNT_EN
    check("rst_cnt", echo_cnt, 0);
`endif
    rst = 1'b0;
    step(3);

    // boundaries: shortest rejected / accepted widths and distance edges
    run_trigger(SAT - 1, 5, 0);
    run_trigger(SAT, MAX_CM, 0);
    run_trigger(SAT + 5, 0, 1);
    run_trigger(SAT + 2, MAX_CM + 1, 1);
    run_trigger(SAT + 1, 1, 2);

    for (int i = 0; i < 8; i++) begin
      step($urandom_range(2, 6));
      run_trigger($urandom_range(SAT - 4, SAT + 30), pick_dist(), $urandom_range(0, 1));
    end

    // trig held for about three full echo periods yields a single echo after release
    run_trigger(3 * (BC + TIMEOUT_US * CLK_PER_US + HC), 0, 0);

    // reset in the middle of an echo
    dist_cm = 9'(MAX_CM);
    trig_pulse(SAT + 3, k);
    rise = k + SAT + 3 + SYNC_LAT + BC;
    exp_q.push_back(rise);
    exp_w_q.push_back(6);
    wait_until(rise + 5);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("mid_rst_eco", eco, 0);
    check("mid_rst_busy", busy, 0);
    echo_exp = 0;
    step(3);
    compare_echoes();
    run_trigger(SAT + 3, 7, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
